// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that sequences three requesters onto one shared spi_master.
// Each grant runs LOAD, BITS shift cycles, CAPTURE and a done pulse, then GAP idle cycles.
module spi_txn_arbiter #(
  parameter int BITS       = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] tx_en,
  input  logic [2:0] rx_en,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  input  logic [2:0] slave_mode,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic [7:0] rx_data0,
  output logic [7:0] rx_data1,
  output logic [7:0] rx_data2,
  output logic       busy,
  output logic       m_load,
  output logic [7:0] m_initial_val,
  output logic       m_send,
  output logic       m_recieve,
  output logic       m_mode,
  output logic [1:0] m_select,
  input  logic [7:0] m_data_out
);

  localparam int CW = $clog2(BITS) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  state_t        state_r;
  logic [1:0]    rr_ptr_r;
  logic [1:0]    id_r;
  logic [CW-1:0] bit_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic          send_dir_r;
  logic          recv_dir_r;

  logic          pick_valid_s;
  logic [1:0]    pick_id_s;
  logic [1:0]    idx_s;
  logic [7:0]    pick_data_s;
  logic          pick_mode_s;
  logic          pick_tx_s;
  logic          pick_rx_s;

  function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    logic [2:0] r;
    s = {1'b0, p} + {1'b0, k};
    r = (s >= 3'd3) ? (s - 3'd3) : s;
    return r[1:0];
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] id);
    case (id)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Round-robin pick: scan from the pointer backwards so the closest requester wins last.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = 2'd0;
    idx_s        = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx_s = wrap3(rr_ptr_r, 2'(k));
      if (req[idx_s]) begin
        pick_valid_s = 1'b1;
        pick_id_s    = idx_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Per-requester operands of the candidate grant.
  always_comb begin
    pick_data_s = 8'h00;
    pick_mode_s = 1'b0;
    pick_tx_s   = 1'b0;
    pick_rx_s   = 1'b0;
    case (pick_id_s)
      2'd0: begin
        pick_data_s = tx_data0; pick_mode_s = slave_mode[0];
        pick_tx_s   = tx_en[0]; pick_rx_s   = rx_en[0];
      end
      2'd1: begin
        pick_data_s = tx_data1; pick_mode_s = slave_mode[1];
        pick_tx_s   = tx_en[1]; pick_rx_s   = rx_en[1];
      end
      2'd2: begin
        pick_data_s = tx_data2; pick_mode_s = slave_mode[2];
        pick_tx_s   = tx_en[2]; pick_rx_s   = rx_en[2];
      end
      default: begin
        pick_data_s = 8'h00;
      end
    endcase
  end

  // Transaction sequencer with all master-facing and requester-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;   rr_ptr_r <= 2'd0;   id_r <= 2'd0;
      bit_cnt_r <= '0;      gap_cnt_r <= '0;
      send_dir_r <= 1'b0;   recv_dir_r <= 1'b0;
      gnt <= 3'b000;        done <= 3'b000;     busy <= 1'b0;
      m_load <= 1'b0;       m_send <= 1'b0;     m_recieve <= 1'b0;
      m_mode <= 1'b0;       m_select <= 2'd0;   m_initial_val <= 8'h00;
      rx_data0 <= 8'h00;    rx_data1 <= 8'h00;  rx_data2 <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 3'b000;
          if (pick_valid_s) begin
            id_r          <= pick_id_s;
            rr_ptr_r      <= wrap3(pick_id_s, 2'd1);
            // A request with no direction selected runs full duplex.
            if (!pick_tx_s && !pick_rx_s) begin
              send_dir_r <= 1'b1;
              recv_dir_r <= 1'b1;
            end else begin
              send_dir_r <= pick_tx_s;
              recv_dir_r <= pick_rx_s;
            end
            state_r       <= ST_LOAD;
            busy          <= 1'b1;
            m_load        <= 1'b1;
            m_initial_val <= pick_data_s;
            m_select      <= pick_id_s + 2'd1;
            m_mode        <= pick_mode_s;
            gnt           <= onehot3(pick_id_s);
          end else begin
            busy     <= 1'b0;
            gnt      <= 3'b000;
            m_load   <= 1'b0;
            m_select <= 2'd0;
            m_mode   <= 1'b0;
          end
        end
        ST_LOAD: begin
          m_load    <= 1'b0;
          m_send    <= send_dir_r;
          m_recieve <= recv_dir_r;
          bit_cnt_r <= '0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
          if (bit_cnt_r == CNT_LAST) begin
            m_send    <= 1'b0;
            m_recieve <= 1'b0;
            state_r   <= ST_CAPTURE;
          end else begin
            state_r   <= ST_SHIFT;
          end
        end
        ST_CAPTURE: begin
          case (id_r)
            2'd0:    rx_data0 <= m_data_out;
            2'd1:    rx_data1 <= m_data_out;
            2'd2:    rx_data2 <= m_data_out;
            default: rx_data0 <= rx_data0;
          endcase
          done     <= onehot3(id_r);
          m_select <= 2'd0;
          m_mode   <= 1'b0;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          done <= 3'b000;
          gnt  <= 3'b000;
          if (GAP_CYCLES > 0) begin
            gap_cnt_r <= '0;
            state_r   <= ST_GAP;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt <= 3'b000;  done <= 3'b000;  busy <= 1'b0;
          m_load <= 1'b0; m_send <= 1'b0;  m_recieve <= 1'b0;
          m_select <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: a transaction-level model predicts each grant,
// a negedge monitor compares the DUT cycle by cycle against the predicted transactions.
module tb_spi_txn_arbiter;

  localparam int BITS = 8;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] req, tx_en, rx_en, slave_mode;
  logic [7:0] txd0, txd1, txd2;
  logic [2:0] gnt, done;
  logic [7:0] rx_data0, rx_data1, rx_data2;
  logic       busy, m_load, m_send, m_recieve, m_mode;
  logic [7:0] m_initial_val;
  logic [1:0] m_select;
  logic [7:0] sr;

  spi_txn_arbiter #(.BITS(BITS), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .req(req), .tx_en(tx_en), .rx_en(rx_en),
    .tx_data0(txd0), .tx_data1(txd1), .tx_data2(txd2), .slave_mode(slave_mode),
    .gnt(gnt), .done(done), .rx_data0(rx_data0), .rx_data1(rx_data1), .rx_data2(rx_data2),
    .busy(busy), .m_load(m_load), .m_initial_val(m_initial_val), .m_send(m_send),
    .m_recieve(m_recieve), .m_mode(m_mode), .m_select(m_select), .m_data_out(sr)
  );

  // Second instance with no gap, two requesters held permanently.
  logic [2:0] gnt_z, done_z;
  logic [7:0] rxz0, rxz1, rxz2, miv_z;
  logic       busy_z, m_load_z, m_send_z, m_recv_z, m_mode_z;
  logic [1:0] m_sel_z;

  spi_txn_arbiter #(.BITS(BITS), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .req(3'b011), .tx_en(3'b000), .rx_en(3'b000),
    .tx_data0(8'h11), .tx_data1(8'h22), .tx_data2(8'h33), .slave_mode(3'b000),
    .gnt(gnt_z), .done(done_z), .rx_data0(rxz0), .rx_data1(rxz1), .rx_data2(rxz2),
    .busy(busy_z), .m_load(m_load_z), .m_initial_val(miv_z), .m_send(m_send_z),
    .m_recieve(m_recv_z), .m_mode(m_mode_z), .m_select(m_sel_z), .m_data_out(8'h00)
  );

  typedef struct {
    int         id;
    logic       t;
    logic       r;
    logic [7:0] data;
    logic       mode;
    int         load_cyc;
    int         done_cyc;
    logic [7:0] rxb;
  } txn_t;

  txn_t       q[$];
  int         cyc = 0;
  int         rr = 0, free_cyc = 0, start_cyc = -1;
  logic [7:0] exp_rx [3];
  logic [7:0] cur_sb = 8'h00;
  logic [7:0] force_sb = 8'h00;
  bit         force_v = 1'b0;
  int         n_chk = 0, n_pass = 0;
  int         bp;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural spi_master: loads, shifts the slave byte in MSB first while receiving.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= 8'h00; bp <= 0;
    end else if (m_load) begin
      sr <= m_initial_val; bp <= 0;
    end else if (m_recieve) begin
      sr <= {sr[6:0], cur_sb[3'(7 - bp)]}; bp <= bp + 1;
    end else if (m_send) begin
      sr <= {sr[6:0], 1'b0};
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
  endtask

  // Reference model: decides a grant for the inputs the DUT samples at the end of this cycle.
  task automatic model_sample();
    txn_t e;
    int   id;
    bit   found;
    logic [2:0] dtx, drx;
    logic [7:0] dd;
    if (rst && cyc >= free_cyc && req != 3'b000) begin
      found = 1'b0; id = 0;
      for (int k = 0; k < 3; k++) begin
        if (!found && req[(rr + k) % 3]) begin
          found = 1'b1; id = (rr + k) % 3;
        end
      end
      dtx = tx_en; drx = rx_en;
      dd  = (id == 0) ? txd0 : (id == 1) ? txd1 : txd2;
      e.id = id; e.t = dtx[id]; e.r = drx[id];
      if (!e.t && !e.r) begin e.t = 1'b1; e.r = 1'b1; end
      e.data = dd; e.mode = slave_mode[id];
      e.load_cyc = cyc + 1; e.done_cyc = cyc + BITS + 3;
      cur_sb = force_v ? force_sb : 8'($urandom);
      force_v = 1'b0;
      e.rxb = e.r ? cur_sb : 8'h00;
      q.push_back(e);
      rr = (id + 1) % 3;
      start_cyc = cyc;
      free_cyc = cyc + BITS + 4 + GAP;
    end
  endtask

  task automatic cyc_go();
    model_sample();
    @(posedge clk); #2;
  endtask

  task automatic drain();
    req = 3'b000;
    repeat (BITS + 6 + GAP) cyc_go();
  endtask

  // Monitor: compares control outputs every cycle and retires transactions at their done cycle.
  always @(negedge clk) begin : mon
    txn_t e;
    logic       eb, el;
    logic [1:0] een, esel;
    logic [2:0] eg, ed;
    int         ld;
    if (rst) begin
      eb = (cyc > start_cyc) && (cyc < free_cyc);
      el = 1'b0; een = 2'b00; esel = 2'd0; eg = 3'b000; ed = 3'b000; ld = -100;
      if (q.size() > 0) begin
        e = q[0]; ld = e.load_cyc;
        if (cyc == ld) el = 1'b1;
        if (cyc > ld && cyc <= ld + BITS) een = {e.t, e.r};
        if (cyc >= ld && cyc <= ld + BITS + 1) esel = 2'(e.id + 1);
        if (cyc >= ld && cyc <= ld + BITS + 2) eg = 3'(1 << e.id);
        if (cyc == e.done_cyc) ed = 3'(1 << e.id);
      end
      check("ctrl{busy,load,send,recv,sel,gnt,done}",
            {busy, m_load, m_send, m_recieve, m_select, gnt, done},
            {eb, el, een, esel, eg, ed});
      if (q.size() > 0 && cyc == ld)
        check("load{mode,val}", {m_mode, m_initial_val}, {e.mode, e.data});
      if (q.size() > 0 && cyc > ld && cyc <= ld + BITS + 1)
        check("mode_held", m_mode, e.mode);
      if (q.size() > 0 && cyc >= e.done_cyc) begin
        exp_rx[e.id] = e.rxb;
        check("rx_data{0,1,2}", {rx_data0, rx_data1, rx_data2}, {exp_rx[0], exp_rx[1], exp_rx[2]});
        void'(q.pop_front());
      end
    end
  end

  int  last_done_z = 0, loads_z = 0;
  bit  have_done_z = 1'b0;
  logic [2:0] prev_gnt_z = 3'b000;

  // Zero-gap instance: next LOAD two cycles after DONE, grants alternate 0,1,0,1.
  always @(negedge clk) begin
    if (!rst) begin
      have_done_z = 1'b0; loads_z = 0;
    end else begin
      if (done_z != 3'b000) begin
        last_done_z = cyc; have_done_z = 1'b1;
      end
      if (m_load_z) begin
        if (have_done_z) check("gap0_spacing", 64'(cyc - last_done_z), 64'd2);
        check("gap0_grant", gnt_z, (loads_z == 0 || prev_gnt_z == 3'b010) ? 3'b001 : 3'b010);
        prev_gnt_z = gnt_z;
        loads_z++;
      end
    end
  end

  initial begin
    rst = 1'b0; req = 3'b000; tx_en = 3'b000; rx_en = 3'b000; slave_mode = 3'b000;
    txd0 = 8'h00; txd1 = 8'h00; txd2 = 8'h00;
    exp_rx[0] = 8'h00; exp_rx[1] = 8'h00; exp_rx[2] = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ctrl", {busy, gnt, done, m_load, m_send, m_recieve, m_mode, m_select, m_initial_val}, 64'd0);
    check("reset_rx", {rx_data0, rx_data1, rx_data2}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b1; free_cyc = cyc; rr = 0;

    // Single full-duplex transfer on requester 0 receiving 3C.
    req = 3'b001; tx_en = 3'b001; rx_en = 3'b001; txd0 = 8'hA5;
    force_sb = 8'h3C; force_v = 1'b1;
    cyc_go();
    drain();
    check("t1_rx0", rx_data0, 8'h3C);

    // All three requesting permanently, full duplex.
    req = 3'b111; tx_en = 3'b111; rx_en = 3'b111;
    repeat (4 * (BITS + 4 + GAP) + 2) cyc_go();
    drain();

    // Requester 1 transmit only, mode 1.
    req = 3'b010; tx_en = 3'b010; rx_en = 3'b000; txd1 = 8'hF0; slave_mode = 3'b010;
    cyc_go();
    drain();

    // Requester 2 with no direction bits.
    req = 3'b100; tx_en = 3'b000; rx_en = 3'b000; slave_mode = 3'b000;
    cyc_go();
    drain();

    // Drop req0 and change its data during SHIFT cycle 3.
    req = 3'b001; tx_en = 3'b001; rx_en = 3'b001; txd0 = 8'h5A;
    cyc_go();
    repeat (3) cyc_go();
    req = 3'b000; txd0 = 8'hFF;
    drain();

    // Reset during SHIFT cycle 4, then a fresh request from pointer 0.
    req = 3'b001;
    cyc_go();
    repeat (4) cyc_go();
    rst = 1'b0; q.delete();
    #1;
    check("midrst_ctrl", {busy, gnt, done, m_load, m_send, m_recieve, m_mode, m_select, m_initial_val}, 64'd0);
    check("midrst_rx", {rx_data0, rx_data1, rx_data2}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b1; rr = 0; free_cyc = cyc; start_cyc = cyc;
    exp_rx[0] = 8'h00; exp_rx[1] = 8'h00; exp_rx[2] = 8'h00;
    req = 3'b110; tx_en = 3'b110; rx_en = 3'b110;
    cyc_go();
    drain();

    // Randomized traffic, inputs changing every cycle.
    repeat (800) begin
      req = 3'($urandom); tx_en = 3'($urandom); rx_en = 3'($urandom);
      slave_mode = 3'($urandom);
      txd0 = 8'($urandom); txd1 = 8'($urandom); txd2 = 8'($urandom);
      cyc_go();
    end
    drain();

    check("queue_empty", 64'(q.size()), 64'd0);
    check("gap0_loads_seen", 64'(loads_z >= 3), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
